pac_sprite_anim: RTL and testbench
==================================

PAC_SPRITE_ANIM -- requirements
Module: pac_sprite_anim

Interface
REQ-001 SHALL have parameter SPRITE_W, default 12, meaning sprite side length in bitmap cells.
REQ-002 SHALL have parameter SCALE, default 2, meaning screen pixels per bitmap cell, with 1, 2 or 4 allowed.
REQ-003 SHALL have parameter COORD_W, default 5, meaning width of the x/y coordinate inputs.
REQ-004 SHALL have parameter ANIM_DIV, default 8, meaning frame_tick pulses per animation step, with a minimum of 1.
REQ-005 SHALL have parameter FRAMES, default 3, meaning animation frame count: 0 = mouth wide, 1 = mouth half, 2 = closed disc.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 frame_tick  in  1  single-cycle pulse, once per video frame.
REQ-009 moving  in  1  sprite is moving, so the animation advances.
REQ-010 dir  in  4  one-hot direction, where L=1000, U=0100, R=0010, D=0001.
REQ-011 req_valid  in  1  pixel lookup request.
REQ-012 x, y  in  COORD_W each  pixel offset within the sprite box.
REQ-013 pix_valid  out  1  lookup result valid.
REQ-014 pixel  out  1  sprite pixel value.
REQ-015 cur_dir  out  4  latched direction.
REQ-016 cur_frame  out  $clog2(FRAMES)  current animation frame.

Function
REQ-017 The direction register SHALL load dir on a frame_tick cycle only if dir has exactly one bit set, and otherwise hold.
REQ-018 The tick counter SHALL increment on frame_tick while moving=1, and on reaching ANIM_DIV-1 SHALL wrap to 0 and advance the frame.
REQ-019 The frame sequence SHALL ping-pong 0,1,...,FRAMES-1,...,1,0, using an internal up/down flag. With FRAMES=1 the frame SHALL remain 0.
REQ-020 While moving=0, the tick counter and the frame SHALL hold their values (the sprite freezes in its current pose).
REQ-021 On a frame_tick with moving falling to 0 in the same cycle, no advance SHALL occur.
REQ-022 The pixel pipeline SHALL have a fixed latency of 2: a request at cycle N SHALL give pix_valid=1 at cycle N+2, with back-to-back requests accepted every cycle and no stall.
REQ-023 Stage 1 SHALL register col=x/SCALE, row=y/SCALE, an in-range flag, and snapshots of cur_dir and cur_frame. A direction or frame change after stage 1 SHALL NOT affect that request.
REQ-024 Stage 2 SHALL register pixel as bit (row*SPRITE_W + col) of the packed bitmap selected by {dir, frame}, where bit 0 is the LSB of the packed constant.
REQ-025 A coordinate x or y >= SPRITE_W*SCALE SHALL produce pixel=0 with pix_valid=1.
REQ-026 Frame 2 SHALL be the same closed-disc bitmap for all directions.
REQ-027 pix_valid SHALL be 0 in any cycle with no matching request issued 2 cycles earlier, and pixel SHALL be 0 whenever pix_valid=0.

Reset
REQ-028 When rst_n=0, all outputs SHALL be cleared asynchronously: pix_valid=0, pixel=0, cur_dir=R (0010), cur_frame=0; the tick counter=0 and the ping-pong flag=up.
REQ-029 Requests in flight when reset asserts SHALL be discarded, and no pix_valid SHALL appear in the 2 cycles after reset release unless new requests are made.

Structure
REQ-030 A shared package pac_pkg SHALL hold the direction constants, SPRITE_W, and all packed sprite bitmaps (4 directions x 2 open-mouth frames, plus the closed disc).
REQ-031 The bitmap lookup SHALL be one combinational sub-module, pac_sprite_rom (inputs dir, frame, row, col; output bit). pac_sprite_anim SHALL contain only the counters, the latch and the pipeline registers.
REQ-032 Bitmap indexing arithmetic SHALL be sized to hold SPRITE_W*SPRITE_W-1, with no truncation.

Verification
REQ-033 Reset then a request at x=0, y=0 -> pix_valid=1 two cycles later; pixel equals the R frame-0 bitmap bit 0; cur_dir=0010.
REQ-034 moving=1 with 8 frame_tick pulses (ANIM_DIV=8) -> cur_frame 0->1; after 24 total pulses the sequence SHALL be 0,1,2,1.
REQ-035 dir=0110 on a frame_tick -> cur_dir unchanged; dir=1000 on a frame_tick -> cur_dir=1000 on the next cycle.
REQ-036 A request at x=24, y=3 (SCALE=2, SPRITE_W=12) -> pix_valid=1 and pixel=0.
REQ-037 A request, then dir changed in the next cycle -> the result uses the old direction's bitmap; a burst of 5 requests on consecutive cycles -> 5 consecutive pix_valid pulses.
REQ-038 rst_n asserted with 2 requests in flight -> pix_valid=0 immediately and through release; cur_frame=0.

Source files
------------

// File: rtl/pac_pkg.sv
// pac_pkg: direction codes, sprite geometry and the packed Pac-Man bitmaps.
package pac_pkg;

  localparam int SPRITE_W = 12;
  localparam int CELLS    = SPRITE_W * SPRITE_W;
  localparam int CELL_W   = $clog2(SPRITE_W);
  localparam int IDX_W    = $clog2(CELLS);

  // Disc radius squared in doubled coordinates; the small margin over
  // (SPRITE_W-1)^2 lets the outermost row/column keep its two centre cells.
  localparam int DISC_R2  = (SPRITE_W - 1) * (SPRITE_W - 1) + 4;

  localparam logic [3:0] DIR_L = 4'b1000;
  localparam logic [3:0] DIR_U = 4'b0100;
  localparam logic [3:0] DIR_R = 4'b0010;
  localparam logic [3:0] DIR_D = 4'b0001;

  typedef enum logic [1:0] {
    MOUTH_WIDE   = 2'd0,
    MOUTH_HALF   = 2'd1,
    MOUTH_CLOSED = 2'd2
  } mouth_e;

  typedef enum logic {
    SWING_UP   = 1'b0,
    SWING_DOWN = 1'b1
  } swing_e;

  // Builds one bitmap. Cell centres are taken in doubled coordinates so the
  // sprite centre lands on an integer (0,0). "along" points toward faceDir,
  // "across" is the absolute perpendicular offset. A cell inside the disc is
  // cut away as mouth when along > 0 and mouthSlope*across <= along, so slope
  // 1 gives a 90-degree wedge, slope 2 a narrower one, and slope 0 no mouth.
  // Bit index is row*SPRITE_W + col, row 0 at the top.
  function automatic logic [CELLS-1:0] makeSprite(input logic [3:0] faceDir,
                                                  input int mouthSlope);
    logic [CELLS-1:0] bits;
    int dx, dy, along, across;
    bits = '0;
    for (int r = 0; r < SPRITE_W; r++) begin
      for (int c = 0; c < SPRITE_W; c++) begin
        dx = 2 * c - (SPRITE_W - 1);
        dy = 2 * r - (SPRITE_W - 1);
        case (faceDir)
          DIR_L:   begin along = -dx; across = dy; end
          DIR_U:   begin along = -dy; across = dx; end
          DIR_D:   begin along = dy;  across = dx; end
          default: begin along = dx;  across = dy; end
        endcase
        if (across < 0) across = -across;
        if (dx * dx + dy * dy <= DISC_R2) begin
          if (mouthSlope == 0 || along <= 0 || mouthSlope * across > along)
            bits[r * SPRITE_W + c] = 1'b1;
        end
      end
    end
    return bits;
  endfunction

  localparam logic [CELLS-1:0] SPR_L_WIDE = makeSprite(DIR_L, 1);
  localparam logic [CELLS-1:0] SPR_U_WIDE = makeSprite(DIR_U, 1);
  localparam logic [CELLS-1:0] SPR_R_WIDE = makeSprite(DIR_R, 1);
  localparam logic [CELLS-1:0] SPR_D_WIDE = makeSprite(DIR_D, 1);
  localparam logic [CELLS-1:0] SPR_L_HALF = makeSprite(DIR_L, 2);
  localparam logic [CELLS-1:0] SPR_U_HALF = makeSprite(DIR_U, 2);
  localparam logic [CELLS-1:0] SPR_R_HALF = makeSprite(DIR_R, 2);
  localparam logic [CELLS-1:0] SPR_D_HALF = makeSprite(DIR_D, 2);
  localparam logic [CELLS-1:0] SPR_DISC   = makeSprite(DIR_R, 0);

endpackage

// File: rtl/pac_sprite_rom.sv
// pac_sprite_rom: combinational bitmap lookup by direction, mouth frame and cell.
module pac_sprite_rom
  import pac_pkg::*;
(
  input  logic [3:0]        dir,
  input  logic [1:0]        frame,
  input  logic [CELL_W-1:0] row,
  input  logic [CELL_W-1:0] col,
  output logic              pix
);

  logic [CELLS-1:0] sprite;
  logic [IDX_W-1:0] idx;

  // Select the bitmap for this pose; the closed disc is shared by all directions.
  always_comb begin
    sprite = SPR_DISC;
    case (frame)
      MOUTH_WIDE: begin
        case (dir)
          DIR_L:   sprite = SPR_L_WIDE;
          DIR_U:   sprite = SPR_U_WIDE;
          DIR_D:   sprite = SPR_D_WIDE;
          default: sprite = SPR_R_WIDE;
        endcase
      end
      MOUTH_HALF: begin
        case (dir)
          DIR_L:   sprite = SPR_L_HALF;
          DIR_U:   sprite = SPR_U_HALF;
          DIR_D:   sprite = SPR_D_HALF;
          default: sprite = SPR_R_HALF;
        endcase
      end
      default: sprite = SPR_DISC;
    endcase
  end

  // Row-major cell index, wide enough for the last cell; anything past it reads 0.
  always_comb begin
    idx = IDX_W'(row) * IDX_W'(SPRITE_W) + IDX_W'(col);
    pix = (int'(idx) < CELLS) ? sprite[idx] : 1'b0;
  end

endmodule

// File: rtl/pac_sprite_anim.sv
// pac_sprite_anim: direction latch, ping-pong mouth animation and a
// two-stage pixel lookup pipeline in front of pac_sprite_rom.
module pac_sprite_anim #(
  parameter  int SPRITE_W = 12,
  parameter  int SCALE    = 2,
  parameter  int COORD_W  = 5,
  parameter  int ANIM_DIV = 8,
  parameter  int FRAMES   = 3,
  localparam int FR_W     = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               moving,
  input  logic [3:0]         dir,
  input  logic               req_valid,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               pix_valid,
  output logic               pixel,
  output logic [3:0]         cur_dir,
  output logic [FR_W-1:0]    cur_frame
);

  import pac_pkg::DIR_R;
  import pac_pkg::CELL_W;
  import pac_pkg::swing_e;
  import pac_pkg::SWING_UP;
  import pac_pkg::SWING_DOWN;
  import pac_pkg::MOUTH_CLOSED;

  localparam int                TICK_W     = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int                BOX        = SPRITE_W * SCALE;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(ANIM_DIV - 1);
  localparam logic [FR_W-1:0]   FRAME_LAST = FR_W'(FRAMES - 1);

  logic [3:0]        dir_q, dir_d;
  logic              dirOneHot;
  logic [TICK_W-1:0] tickCnt_q, tickCnt_d;
  logic [FR_W-1:0]   frame_q, frame_d;
  swing_e            swing_q, swing_d;

  logic              inRange_d;
  logic [CELL_W-1:0] row_d, col_d;
  logic              s1Valid_q, s1InRange_q;
  logic [CELL_W-1:0] s1Row_q, s1Col_q;
  logic [3:0]        s1Dir_q;
  logic [FR_W-1:0]   s1Frame_q;
  logic [1:0]        romFrame;
  logic              romPix;
  logic              s2Valid_q, s2Pixel_q;

  assign dirOneHot = (dir != 4'b0000) && ((dir & (dir - 4'd1)) == 4'b0000);

  // Accept a new heading only on a frame tick and only if it is cleanly one-hot.
  always_comb begin
    dir_d = dir_q;
    if (frame_tick && dirOneHot) dir_d = dir;
  end

  // Heading register, facing right out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_q <= DIR_R;
    else        dir_q <= dir_d;
  end

  // Animation state register: tick divider, current frame and swing direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tickCnt_q <= '0;
      frame_q   <= '0;
      swing_q   <= SWING_UP;
    end else begin
      tickCnt_q <= tickCnt_d;
      frame_q   <= frame_d;
      swing_q   <= swing_d;
    end
  end

  // Count moving frame ticks; each divider wrap steps the frame back and forth
  // between 0 and FRAMES-1, and a stopped sprite keeps its pose and count.
  always_comb begin
    tickCnt_d = tickCnt_q;
    frame_d   = frame_q;
    swing_d   = swing_q;
    if (frame_tick && moving) begin
      if (tickCnt_q == TICK_LAST) begin
        tickCnt_d = '0;
        if (FRAMES > 1) begin
          if (swing_q == SWING_UP) begin
            if (frame_q == FRAME_LAST) begin
              frame_d = frame_q - FR_W'(1);
              swing_d = SWING_DOWN;
            end else begin
              frame_d = frame_q + FR_W'(1);
            end
          end else begin
            if (frame_q == '0) begin
              frame_d = frame_q + FR_W'(1);
              swing_d = SWING_UP;
            end else begin
              frame_d = frame_q - FR_W'(1);
            end
          end
        end
      end else begin
        tickCnt_d = tickCnt_q + TICK_W'(1);
      end
    end
  end

  // Outputs are direct views of the registered state.
  always_comb begin
    cur_dir   = dir_q;
    cur_frame = frame_q;
    pix_valid = s2Valid_q;
    pixel     = s2Pixel_q;
  end

  // Screen offset to bitmap cell; out-of-box coordinates are flagged, not clipped.
  always_comb begin
    inRange_d = (int'(x) < BOX) && (int'(y) < BOX);
    col_d     = CELL_W'(int'(x) / SCALE);
    row_d     = CELL_W'(int'(y) / SCALE);
  end

  // Stage 1: capture the cell and a snapshot of the pose so later pose
  // changes cannot leak into a request already accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q   <= 1'b0;
      s1InRange_q <= 1'b0;
      s1Row_q     <= '0;
      s1Col_q     <= '0;
      s1Dir_q     <= DIR_R;
      s1Frame_q   <= '0;
    end else begin
      s1Valid_q   <= req_valid;
      s1InRange_q <= inRange_d;
      s1Row_q     <= row_d;
      s1Col_q     <= col_d;
      s1Dir_q     <= dir_q;
      s1Frame_q   <= frame_q;
    end
  end

  // Frames beyond the two open-mouth poses all show the closed disc.
  always_comb begin
    romFrame = 2'(s1Frame_q);
    if (int'(s1Frame_q) >= 2) romFrame = MOUTH_CLOSED;
  end

  pac_sprite_rom uRom (
    .dir   (s1Dir_q),
    .frame (romFrame),
    .row   (s1Row_q),
    .col   (s1Col_q),
    .pix   (romPix)
  );

  // Stage 2: register the looked-up bit, forced to 0 when idle or off the box.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Valid_q <= 1'b0;
      s2Pixel_q <= 1'b0;
    end else begin
      s2Valid_q <= s1Valid_q;
      s2Pixel_q <= s1Valid_q && s1InRange_q && romPix;
    end
  end

endmodule

// File: tb/tb_pac_sprite_anim.sv
// tb_pac_sprite_anim: directed checks of the direction latch, animation
// sequence and pixel pipeline. Expected pixels are worked out by hand from
// the sprite geometry: doubled offsets dx=2c-11, dy=2r-11, inside the disc
// when dx*dx+dy*dy <= 125, mouth cut when along>0 and slope*across <= along.
module tb_pac_sprite_anim;

  localparam int         COORD_W = 5;
  localparam logic [3:0] D_L = 4'b1000;
  localparam logic [3:0] D_U = 4'b0100;
  localparam logic [3:0] D_R = 4'b0010;
  localparam logic [3:0] D_D = 4'b0001;

  logic               clk;
  logic               rst_n;
  logic               frame_tick;
  logic               moving;
  logic [3:0]         dir;
  logic               req_valid;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               pix_valid;
  logic               pixel;
  logic [3:0]         cur_dir;
  logic [1:0]         cur_frame;

  int numCompared   = 0;
  int numMismatched = 0;

  int   burstX [5] = '{18, 18, 0, 24, 13};
  int   burstY [5] = '{6, 8, 10, 3, 1};
  logic burstE [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  pac_sprite_anim #(
    .SPRITE_W (12),
    .SCALE    (2),
    .COORD_W  (COORD_W),
    .ANIM_DIV (8),
    .FRAMES   (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .moving     (moving),
    .dir        (dir),
    .req_valid  (req_valid),
    .x          (x),
    .y          (y),
    .pix_valid  (pix_valid),
    .pixel      (pixel),
    .cur_dir    (cur_dir),
    .cur_frame  (cur_frame)
  );

  // 100 MHz free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numCompared++;
    if (got !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic reqV, input logic [COORD_W-1:0] xs,
                               input logic [COORD_W-1:0] ys);
    req_valid = reqV;
    x         = xs;
    y         = ys;
  endtask

  // One isolated request: idle at +1, result at +2, idle again at +3.
  task automatic lookupCheck(input string tag, input int xs, input int ys, input logic expPix);
    applyStimulus(1'b1, COORD_W'(xs), COORD_W'(ys));
    stepCycle();
    applyStimulus(1'b0, '0, '0);
    checkOutput({tag, "_lat1"}, pix_valid, 0);
    stepCycle();
    checkOutput({tag, "_vld"}, pix_valid, 1);
    checkOutput({tag, "_pix"}, pixel, expPix);
    stepCycle();
    checkOutput({tag, "_idle"}, pix_valid, 0);
    checkOutput({tag, "_idle0"}, pixel, 0);
  endtask

  task automatic pulseTicks(input int n, input logic mov);
    for (int i = 0; i < n; i++) begin
      moving     = mov;
      frame_tick = 1'b1;
      stepCycle();
      frame_tick = 1'b0;
      stepCycle();
    end
  endtask

  task automatic latchDir(input logic [3:0] d);
    dir        = d;
    frame_tick = 1'b1;
    stepCycle();
    frame_tick = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    moving     = 1'b0;
    dir        = D_R;
    applyStimulus(1'b0, '0, '0);
    stepCycle();
    stepCycle();
    checkOutput("rst_vld", pix_valid, 0);
    checkOutput("rst_pix", pixel, 0);
    checkOutput("rst_dir", cur_dir, 4'b0010);
    checkOutput("rst_frame", cur_frame, 0);
    rst_n = 1'b1;
    stepCycle();

    // Facing right, mouth wide.
    lookupCheck("r0_x0y0", 0, 0, 1'b0);
    checkOutput("r0_dir", cur_dir, 4'b0010);
    lookupCheck("r0_mouth", 20, 10, 1'b0);
    lookupCheck("r0_upper", 16, 4, 1'b1);
    lookupCheck("r0_leftedge", 0, 10, 1'b1);
    lookupCheck("r0_top_oddx", 11, 0, 1'b1);
    lookupCheck("r0_top_c6", 13, 1, 1'b1);
    lookupCheck("r0_oob_x24", 24, 3, 1'b0);
    lookupCheck("r0_oob_wrap", 24, 8, 1'b0);
    lookupCheck("r0_oob_y24", 0, 24, 1'b0);

    // Direction latch: only one-hot values on a frame tick load.
    latchDir(4'b0110);
    checkOutput("dir_twohot", cur_dir, 4'b0010);
    latchDir(4'b0000);
    checkOutput("dir_zero", cur_dir, 4'b0010);
    dir = D_L;
    stepCycle();
    checkOutput("dir_notick", cur_dir, 4'b0010);
    latchDir(D_L);
    checkOutput("dir_left", cur_dir, 4'b1000);
    checkOutput("dir_noanim", cur_frame, 0);

    // Facing left, mouth wide.
    lookupCheck("l0_mouth", 0, 10, 1'b0);
    lookupCheck("l0_rightedge", 23, 10, 1'b1);
    lookupCheck("l0_body", 20, 10, 1'b1);
    lookupCheck("l0_oob", 24, 8, 1'b0);

    // Facing up, mouth wide.
    latchDir(D_U);
    checkOutput("dir_up", cur_dir, 4'b0100);
    lookupCheck("u0_mouth_top", 11, 0, 1'b0);
    lookupCheck("u0_mouth_in", 16, 4, 1'b0);
    lookupCheck("u0_body", 20, 10, 1'b1);

    // Facing down, mouth wide.
    latchDir(D_D);
    checkOutput("dir_down", cur_dir, 4'b0001);
    lookupCheck("d0_mouth", 12, 18, 1'b0);
    lookupCheck("d0_top", 11, 0, 1'b1);

    // A request keeps the heading it saw at stage 1 (right would give 1 here).
    applyStimulus(1'b1, 5'd12, 5'd18);
    stepCycle();
    applyStimulus(1'b0, '0, '0);
    dir        = D_R;
    frame_tick = 1'b1;
    stepCycle();
    frame_tick = 1'b0;
    checkOutput("snap_vld", pix_valid, 1);
    checkOutput("snap_pix", pixel, 0);
    checkOutput("snap_dir", cur_dir, 4'b0010);
    stepCycle();

    // Animation: 8 moving ticks per step, sequence 0,1,2,1,0,1.
    pulseTicks(7, 1'b1);
    checkOutput("anim_7", cur_frame, 0);
    pulseTicks(1, 1'b1);
    checkOutput("anim_8", cur_frame, 1);
    lookupCheck("r1_upper", 18, 6, 1'b1);
    lookupCheck("r1_mouth", 18, 8, 1'b0);
    pulseTicks(8, 1'b1);
    checkOutput("anim_16", cur_frame, 2);
    lookupCheck("disc_right", 20, 10, 1'b1);
    pulseTicks(8, 1'b1);
    checkOutput("anim_24", cur_frame, 1);
    pulseTicks(8, 1'b0);
    checkOutput("anim_frozen", cur_frame, 1);
    pulseTicks(4, 1'b1);
    pulseTicks(3, 1'b0);
    pulseTicks(3, 1'b1);
    checkOutput("anim_hold_cnt", cur_frame, 1);
    pulseTicks(1, 1'b1);
    checkOutput("anim_down0", cur_frame, 0);
    pulseTicks(8, 1'b1);
    checkOutput("anim_bounce", cur_frame, 1);
    moving = 1'b0;

    // Five back-to-back requests at frame 1 facing right.
    for (int i = 0; i < 7; i++) begin
      if (i < 5) applyStimulus(1'b1, COORD_W'(burstX[i]), COORD_W'(burstY[i]));
      else       applyStimulus(1'b0, '0, '0);
      stepCycle();
      if (i == 0) begin
        checkOutput("burst_pre", pix_valid, 0);
      end else if (i <= 5) begin
        checkOutput($sformatf("burst%0d_vld", i - 1), pix_valid, 1);
        checkOutput($sformatf("burst%0d_pix", i - 1), pixel, burstE[i - 1]);
      end else begin
        checkOutput("burst_post", pix_valid, 0);
      end
    end

    // Reset with two requests in flight.
    latchDir(D_L);
    applyStimulus(1'b1, 5'd18, 5'd6);
    stepCycle();
    applyStimulus(1'b1, 5'd0, 5'd10);
    stepCycle();
    applyStimulus(1'b0, '0, '0);
    checkOutput("inflight_vld", pix_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_vld", pix_valid, 0);
    checkOutput("arst_pix", pixel, 0);
    checkOutput("arst_frame", cur_frame, 0);
    checkOutput("arst_dir", cur_dir, 4'b0010);
    for (int i = 0; i < 2; i++) begin
      stepCycle();
      checkOutput($sformatf("inrst%0d_vld", i), pix_valid, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput($sformatf("postrst%0d_vld", i), pix_valid, 0);
      checkOutput($sformatf("postrst%0d_pix", i), pixel, 0);
    end

    lookupCheck("after_rst_x0y0", 0, 0, 1'b0);
    lookupCheck("after_rst_edge", 0, 10, 1'b1);
    checkOutput("after_rst_dir", cur_dir, 4'b0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
